// File: rtl/ysyx_23060171_ifu.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time over a valid/ready
// channel and presents each fetched instruction with its PC to the IDU.
module ysyx_23060171_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   input  logic        mem_rsp_err,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_err
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StOut} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic        pend_valid_q, pend_valid_d;
   logic        drop_q, drop_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        inst_err_q, inst_err_d;
   logic        go_req;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pend_pc_d    = pend_pc_q;
      pend_valid_d = pend_valid_q;
      drop_d       = drop_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_err_d   = inst_err_q;
      go_req       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (redirect_valid) begin
               pc_d = redirect_pc;
            end
            go_req = 1'b1;
         end
         StReq: begin
            // The outstanding request keeps its address; a redirect is parked in pend_pc.
            if (redirect_valid) begin
               pend_pc_d    = redirect_pc;
               pend_valid_d = 1'b1;
            end
            if (mem_req_ready) begin
               state_d = StWait;
               drop_d  = drop_q | pend_valid_q | redirect_valid;
            end
         end
         StWait: begin
            if (redirect_valid) begin
               pend_pc_d    = redirect_pc;
               pend_valid_d = 1'b1;
               drop_d       = 1'b1;
            end
            if (mem_rsp_valid) begin
               if (drop_q || redirect_valid) begin
                  pc_d         = redirect_valid ? redirect_pc : pend_pc_q;
                  drop_d       = 1'b0;
                  pend_valid_d = 1'b0;
                  go_req       = 1'b1;
               end else begin
                  inst_d     = mem_rsp_data;
                  inst_err_d = mem_rsp_err;
                  inst_pc_d  = pc_q;
                  state_d    = StOut;
               end
            end
         end
         StOut: begin
            // Redirect wins over a simultaneous consume.
            if (redirect_valid) begin
               pc_d   = redirect_pc;
               go_req = 1'b1;
            end else if (inst_ready) begin
               pc_d   = pc_q + 32'd4;
               go_req = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // A misaligned PC never reaches memory; it is reported as a faulting instruction.
      if (go_req) begin
         if (pc_d[1:0] != 2'b00) begin
            state_d    = StOut;
            inst_d     = 32'h0;
            inst_err_d = 1'b1;
            inst_pc_d  = pc_d;
         end else begin
            state_d = StReq;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         pend_pc_q    <= RESET_PC;
         pend_valid_q <= 1'b0;
         drop_q       <= 1'b0;
         inst_q       <= 32'h0;
         inst_pc_q    <= RESET_PC;
         inst_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pend_pc_q    <= pend_pc_d;
         pend_valid_q <= pend_valid_d;
         drop_q       <= drop_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_err_q   <= inst_err_d;
      end
   end

   assign mem_req_valid = (state_q == StReq);
   assign mem_req_addr  = pc_q;
   assign inst_valid    = (state_q == StOut);
   assign inst          = inst_q;
   assign inst_pc       = inst_pc_q;
   assign inst_err      = inst_err_q;

endmodule

// File: tb/tb_ysyx_23060171_ifu.sv
// Scoreboard bench for the IFU: a latency-programmable memory model plus expected request
// and instruction queues checked whenever the DUT hands something off.
module tb_ysyx_23060171_ifu;

   localparam logic [31:0] ResetPc = 32'h8000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        mem_rsp_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_err;

   int          n_checks = 0;
   int          n_errors = 0;
   int          lat      = 1;
   logic [31:0] err_addr = 32'hffff_ffff;
   logic [31:0] req_q[$];
   exp_t        inst_q[$];

   ysyx_23060171_ifu #(.RESET_PC(ResetPc)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .mem_rsp_err    (mem_rsp_err),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_err       (inst_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] img(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (inst_valid) break;
      end
      chk("inst_valid_timeout", {31'b0, inst_valid}, 32'd1);
   endtask

   // Memory: accepts a request, answers lat cycles later with img(addr).
   initial begin
      logic        busy;
      int          cnt;
      logic [31:0] rsp_addr;
      busy          = 1'b0;
      cnt           = 0;
      rsp_addr      = '0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      mem_rsp_err   = 1'b0;
      forever begin
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         if (busy) begin
            cnt--;
            if (cnt == 0) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_data  = img(rsp_addr);
               mem_rsp_err   = (rsp_addr == err_addr);
               busy          = 1'b0;
            end
         end
         if (rst && mem_req_valid && mem_req_ready) begin
            busy     = 1'b1;
            cnt      = lat;
            rsp_addr = mem_req_addr;
         end
      end
   end

   // Scoreboard monitor: every request and every consumed instruction must be expected.
   initial begin
      forever begin
         @(negedge clk);
         if (rst && mem_req_valid && mem_req_ready) begin
            logic [31:0] e;
            e = 32'hffff_ffff;
            if (req_q.size() != 0) e = req_q.pop_front();
            chk("req_addr", mem_req_addr, e);
         end
         if (rst && inst_valid && inst_ready && !redirect_valid) begin
            exp_t e;
            e = '{pc: 32'hffff_ffff, data: 32'hffff_ffff, err: 1'b1};
            if (inst_q.size() != 0) e = inst_q.pop_front();
            chk("inst_pc", inst_pc, e.pc);
            chk("inst", inst, e.data);
            chk("inst_err", {31'b0, inst_err}, {31'b0, e.err});
         end
      end
   end

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem_req_ready  = 1'b0;
      inst_ready     = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
      chk("rst_req_addr", mem_req_addr, ResetPc);
      chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_pc, ResetPc);
      chk("rst_inst_err", {31'b0, inst_err}, 32'd0);

      // Streaming fetch: one instruction every third cycle.
      for (int i = 0; i < 3; i++) begin
         logic [31:0] a;
         a = ResetPc + 32'(4 * i);
         req_q.push_back(a);
         inst_q.push_back('{pc: a, data: img(a), err: 1'b0});
      end
      mem_req_ready = 1'b1;
      inst_ready    = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stream_valid_cycle", {31'b0, inst_valid}, {31'b0, (i % 3 == 0) && (i != 0)});
      end

      // Asynchronous reset while a request is pending, then hold off the memory.
      cyc(1);
      mem_req_ready = 1'b0;
      inst_ready    = 1'b0;
      rst           = 1'b0;
      #1;
      chk("async_rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
      chk("async_rst_req_addr", mem_req_addr, ResetPc);
      cyc(1);
      rst = 1'b1;
      cyc(1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_req_valid", {31'b0, mem_req_valid}, 32'd1);
         chk("stall_req_addr", mem_req_addr, ResetPc);
      end
      cyc(1);
      req_q.push_back(ResetPc);
      inst_q.push_back('{pc: ResetPc, data: img(ResetPc), err: 1'b0});
      mem_req_ready = 1'b1;

      // IDU back-pressure: outputs held, no new request.
      wait_valid();
      for (int i = 0; i < 4; i++) begin
         chk("hold_inst", inst, img(ResetPc));
         chk("hold_inst_pc", inst_pc, ResetPc);
         chk("hold_inst_err", {31'b0, inst_err}, 32'd0);
         chk("hold_no_req", {31'b0, mem_req_valid}, 32'd0);
         @(negedge clk);
      end
      cyc(1);
      req_q.push_back(ResetPc + 32'd4);
      lat        = 4;
      inst_ready = 1'b1;

      // Redirect while waiting on a slow response: that response is dropped.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_req_valid && mem_req_ready) break;
      end
      cyc(1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0100;
      req_q.push_back(32'h8000_0100);
      lat        = 1;
      inst_ready = 1'b0;
      cyc(1);
      redirect_valid = 1'b0;

      // Redirect and consume in the same OUT cycle: redirect wins.
      wait_valid();
      chk("redir_wait_pc", inst_pc, 32'h8000_0100);
      chk("redir_wait_inst", inst, img(32'h8000_0100));
      cyc(1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0040;
      inst_ready     = 1'b1;
      req_q.push_back(32'h8000_0040);
      cyc(1);
      redirect_valid = 1'b0;
      inst_ready     = 1'b0;

      // Misaligned redirect target faults without touching memory.
      wait_valid();
      chk("redir_out_pc", inst_pc, 32'h8000_0040);
      chk("redir_out_inst", inst, img(32'h8000_0040));
      cyc(1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0102;
      cyc(1);
      redirect_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("misal_valid", {31'b0, inst_valid}, 32'd1);
         chk("misal_err", {31'b0, inst_err}, 32'd1);
         chk("misal_pc", inst_pc, 32'h8000_0102);
         chk("misal_inst", inst, 32'd0);
         chk("misal_no_req", {31'b0, mem_req_valid}, 32'd0);
      end

      // Access fault from memory.
      cyc(1);
      err_addr = 32'h8000_0200;
      req_q.push_back(32'h8000_0200);
      inst_q.push_back('{pc: 32'h8000_0200, data: img(32'h8000_0200), err: 1'b1});
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0200;
      inst_ready     = 1'b1;
      cyc(1);
      redirect_valid = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         if (req_q.size() == 0 && inst_q.size() == 0) break;
      end
      #1 mem_req_ready = 1'b0;
      chk("req_q_drained", req_q.size(), 32'd0);
      chk("inst_q_drained", inst_q.size(), 32'd0);
      cyc(3);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ysyx_23060171_ifu.md
Name: ysyx_23060171_ifu

Overview:
Instruction fetch unit. It sits directly upstream of the decode/execute datapath and replaces the combinational instruction-memory lookup. It owns the PC and issues word fetches over a valid/ready request channel with variable-latency responses. Each fetched instruction is presented, with its PC, on a valid/ready output to the IDU; control flow changes come back through a redirect input.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset; asserted while 0.
redirect_valid  in  1  one-cycle pulse; next fetch comes from redirect_pc.
redirect_pc  in  32  branch/jump target.
mem_req_valid  out  1  fetch request valid.
mem_req_ready  in  1  memory accepts request.
mem_req_addr  out  32  word fetch address.
mem_rsp_valid  in  1  response valid; one pulse per accepted request.
mem_rsp_data  in  32  fetched word.
mem_rsp_err  in  1  access fault, qualified by mem_rsp_valid.
inst_valid  out  1  instruction available to IDU.
inst_ready  in  1  IDU consumes instruction.
inst  out  32  instruction word.
inst_pc  out  32  PC of inst.
inst_err  out  1  fetch fault (access error or misaligned PC).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, pc=RESET_PC, drop=0, pend_valid=0.
  - mem_req_valid=0, mem_req_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=RESET_PC, inst_err=0.
  - Reset mid-transaction abandons it; a later mem_rsp_valid is ignored until a new request is accepted.
- States:
  - IDLE: go to REQ next cycle.
  - REQ: mem_req_valid=1, mem_req_addr=pc.
    - Address is held stable until mem_req_ready=1.
    - On handshake, go to WAIT.
  - WAIT: mem_req_valid=0. Wait for mem_rsp_valid. mem_rsp_valid outside WAIT is ignored; memory returns data no earlier than the cycle after acceptance.
    - On response with drop=0: register inst=mem_rsp_data, inst_err=mem_rsp_err, inst_pc=pc; go to OUT.
    - On response with drop=1: discard it; pc=pend_pc, drop=0, pend_valid=0; go to REQ.
  - OUT: inst_valid=1; inst, inst_pc and inst_err are held stable while inst_ready=0.
    - On inst_ready=1: pc=pc+4 (mod 2^32, wraps to 0), go to REQ.
- Redirect handling (redirect_valid=1):
  - REQ, no handshake this cycle: latch pend_pc=redirect_pc, pend_valid=1. The current request stays unchanged (address stability); on its handshake, set drop=1.
  - REQ, handshake this cycle: latch pend_pc, drop=1, go to WAIT.
  - WAIT: latch pend_pc, drop=1. If mem_rsp_valid arrives in the same cycle, that response is discarded.
  - OUT: inst_valid deasserts next cycle, pc=redirect_pc, go to REQ. This wins over a simultaneous inst_ready; the IDU must treat that instruction as not taken.
  - IDLE: pc=redirect_pc.
  - Multiple redirects before resolution: the latest value wins.
  - On the REQ→WAIT handshake, pend_valid=1 forces drop=1.
- Misaligned PC: if pc[1:0]≠0 on entry to REQ, no memory request is issued. Go straight to OUT with inst=0, inst_err=1, inst_pc=pc.
- Latency: with mem_req_ready=1, a 1-cycle response and inst_ready=1, the sequence is REQ, WAIT, OUT, giving 1 instruction per 3 cycles. The first inst_valid comes 3 cycles after reset release (IDLE, REQ, WAIT).
- At most one memory transaction is outstanding.

Test Plan:
1. Reset release, memory always ready, 1-cycle latency, inst_ready=1 → requests at 0x80000000, 0x80000004, 0x80000008; inst/inst_pc match the memory image; inst_valid high every third cycle.
2. Hold mem_req_ready=0 for 5 cycles → mem_req_valid stays 1 and mem_req_addr is constant at 0x80000000; WAIT is entered only after ready.
3. inst_ready=0 for 4 cycles in OUT → inst, inst_pc and inst_err are stable; no new request; pc advances by 4 only after the handshake.
4. Redirect to 0x80000100 during WAIT, response arriving 3 cycles later → that response is never presented; the next request is to 0x80000100.
5. In OUT, redirect_valid and inst_ready both high with redirect_pc=0x80000040 → next request address is 0x80000040, not pc+4.
6. Redirect to 0x80000102 → no mem_req_valid; inst_valid=1, inst_err=1, inst_pc=0x80000102. Separately, mem_rsp_err=1 → inst_err=1 with that response's inst_pc.
